md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts one HI/LO operation per issue from the EX stage and computes its result at issue.
- Holds a busy window of fixed latency, then commits the result to HI/LO.
- Drives the stall request that the decode stage ORs into its hazard logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  EX-stage instruction is an HI/LO op, valid this cycle
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded rt operand
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- stall_md  out  1  stall request to the decode stage

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high.
- Reset: hi=0, lo=0, busy=0, counter=0, pending registers=0, state IDLE. This applies immediately, including mid-operation; an in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, md_op in 0..3, at posedge:
  - Compute the 64-bit result from rs_val/rt_val into pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 and go to RUN.
- IDLE, start=1, md_op=4: hi<=rs_val at that edge; no busy.
- IDLE, start=1, md_op=5: lo<=rs_val at that edge; no busy.
- IDLE, reserved op: no effect.
- RUN, each edge: decrement the counter.
- RUN, edge where the counter equals 1:
  - hi<=pend_hi, lo<=pend_lo.
  - busy<=0, state IDLE.
  - busy is therefore high for exactly N cycles, and the new hi/lo are visible in the first cycle busy is low.
- start while in RUN is ignored. This is illegal given correct stalling; the bench flags it as an error.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}.
  - MULTU: unsigned 32x32 -> 64, {hi,lo}.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Division by zero, default:
  - DIV/DIVU with rt_val=0 commit lo=32'hFFFFFFFF, hi=rs_val after DIV_CYCLES.
  - DIV with rs=32'h80000000 and rt=32'hFFFFFFFF commits lo=32'h80000000, hi=0.
- stall_md = md_use_D & (busy | start). This is combinational and covers the issue cycle, so a back-to-back mfhi stalls.
- hi/lo are never partially updated; mfhi/mflo read them directly.

Optional Feature:
- Macro: MD_DIV0_HOLD_EN.
- Defined: DIV/DIVU with rt_val=0 still runs the full busy window, but hi/lo keep their prior values at commit.
- Undefined: the division-by-zero default values above.

Decomposition:
- Shared package/header md_defs:
  - md_op encodings MD_MULT..MD_MTLO.
  - State encodings IDLE/RUN.
  - Default latency constants.
- One sub-module md_alu: purely combinational 64-bit result from md_op, rs_val, rt_val, including the divide special cases. It is instantiated once; the sequencer registers its output at issue.

Test Plan:
- MULT with rs=32'hFFFFFFFD (-3), rt=5 -> busy high for 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; no change to hi/lo before busy falls.
- MULTU with rs=32'hFFFFFFFF, rt=2 -> after 5 cycles hi=1, lo=32'hFFFFFFFE.
- DIV with rs=-7, rt=2 -> busy for 10 cycles; then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU with rs=7, rt=2 -> lo=3, hi=1.
- MTHI with rs=32'h12345678 while idle -> hi=32'h12345678 at the next edge, busy stays 0. MTLO while RUN -> ignored and flagged.
- md_use_D=1 in the issue cycle and in every busy cycle -> stall_md=1 exactly 1+N cycles, then 0 in the commit-visible cycle.
- Reset asserted mid-DIV (cycle 4), asynchronously between edges -> hi=lo=0 and busy=0 immediately. With MD_DIV0_HOLD_EN: DIV by 0 with hi=5 -> hi still 5 after 10 cycles.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared definitions for the md_sched multiply/divide sequencer:
// operation and state encodings, default latencies and op classifiers.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W_DEF       = 4;

  function automatic logic md_is_arith(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// EX/D-stage side of the multiply/divide sequencer: issue operands,
// decode-stage stall request and the architectural HI/LO view.
interface md_sched_if;
  import md_sched_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_D,
    input  hi, lo, busy, stall_md
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_D,
    output hi, lo, busy, stall_md
  );

endinterface

// File: rtl/md_sched_alu.sv
// md_alu: combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU,
// including divide-by-zero and signed-overflow special cases.
module md_alu
  import md_sched_pkg::*;
(
  input  md_op_e      i_md_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [63:0] o_result
);

  logic               w_div0;
  logic               w_sovf;
  logic [31:0]        w_sdivisor;
  logic [31:0]        w_udivisor;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;

  assign w_div0 = (i_rt_val == 32'd0);
  assign w_sovf = (i_rs_val == 32'h8000_0000) && (i_rt_val == 32'hFFFF_FFFF);

  // Special cases are resolved below; feed the dividers a harmless divisor then.
  assign w_sdivisor = (w_div0 || w_sovf) ? 32'd1 : i_rt_val;
  assign w_udivisor = w_div0 ? 32'd1 : i_rt_val;

  assign w_smul = $signed({{32{i_rs_val[31]}}, i_rs_val}) * $signed({{32{i_rt_val[31]}}, i_rt_val});
  assign w_umul = {32'd0, i_rs_val} * {32'd0, i_rt_val};
  assign w_squo = $signed(i_rs_val) / $signed(w_sdivisor);
  assign w_srem = $signed(i_rs_val) % $signed(w_sdivisor);
  assign w_uquo = i_rs_val / w_udivisor;
  assign w_urem = i_rs_val % w_udivisor;

  always_comb begin
    o_result = 64'd0;
    case (i_md_op)
      MD_MULT:  o_result = w_smul;
      MD_MULTU: o_result = w_umul;
      MD_DIV: begin
        if (w_div0)      o_result = {i_rs_val, 32'hFFFF_FFFF};
        else if (w_sovf) o_result = {32'd0, 32'h8000_0000};
        else             o_result = {w_srem, w_squo};
      end
      MD_DIVU: begin
        if (w_div0) o_result = {i_rs_val, 32'hFFFF_FFFF};
        else        o_result = {w_urem, w_uquo};
      end
      default:  o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: fixed-latency HI/LO multiply/divide sequencer with decode stall.
// Optional MD_DIV0_HOLD_EN: divide-by-zero keeps prior HI/LO at commit.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  md_state_e   r_state;
  md_state_e   w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_alu_result;
  logic        w_idle_start;
  logic        w_issue;
  logic        w_commit;
  logic        w_busy;
`ifdef MD_DIV0_HOLD_EN
  logic        r_pend_div0;
`endif

  md_alu u_alu (
    .i_md_op  (bus.md_op),
    .i_rs_val (bus.rs_val),
    .i_rt_val (bus.rt_val),
    .o_result (w_alu_result)
  );

  assign w_idle_start = (r_state == IDLE) && bus.start;
  assign w_issue      = w_idle_start && md_is_arith(bus.md_op);
  assign w_commit     = (r_state == RUN) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next_state = RUN;
      RUN:     if (w_commit) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state == RUN);
    bus.busy     = w_busy;
    bus.stall_md = bus.md_use_D & (w_busy | bus.start);
    bus.hi       = r_hi;
    bus.lo       = r_lo;
  end

  // Result is captured at issue; HI/LO only move together at commit or on MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MD_DIV0_HOLD_EN
      r_pend_div0 <= 1'b0;
`endif
    end else begin
      if (w_issue) begin
        {r_pend_hi, r_pend_lo} <= w_alu_result;
        r_cnt <= md_is_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`ifdef MD_DIV0_HOLD_EN
        r_pend_div0 <= md_is_div(bus.md_op) && (bus.rt_val == 32'd0);
`endif
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_commit) begin
`ifdef MD_DIV0_HOLD_EN
        if (!r_pend_div0) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
`else
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
`endif
      end else if (w_idle_start && (bus.md_op == MD_MTHI)) begin
        r_hi <= bus.rs_val;
      end else if (w_idle_start && (bus.md_op == MD_MTLO)) begin
        r_lo <= bus.rs_val;
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (default 5/10-cycle latencies).
// Expected HI/LO values are hand-computed; MD_DIV0_HOLD_EN selects div-by-zero expectations.
module tb_md_sched;
  import md_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   illegal_starts = 0;

  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op, count busy/stall cycles, check commit values.
  // inject>0 drives an illegal MTLO start in that busy cycle.
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          n;
    int          stalls;
    logic        early;
    hi0    = bus.hi;
    lo0    = bus.lo;
    n      = 0;
    stalls = 0;
    early  = 1'b0;
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    #1;
    if (bus.stall_md) stalls++;
    tick();
    bus.start = 1'b0;
    while (bus.busy && n < 40) begin
      n++;
      if (bus.stall_md) stalls++;
      if (bus.hi !== hi0 || bus.lo !== lo0) early = 1'b1;
      if (n == inject) begin
        bus.start  = 1'b1;
        bus.md_op  = MD_MTLO;
        bus.rs_val = 32'hDEAD_BEEF;
        illegal_starts++;
        $display("note: illegal start during RUN at t=%0t (must be ignored)", $time);
      end
      tick();
      bus.start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_early_hilo"}, {31'd0, early}, 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
    if (bus.md_use_D) begin
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_n + 1));
      chk({tag, "_stall_after"}, {31'd0, bus.stall_md}, 32'd0);
    end
    $display("txn %s op=%0d rs=%h rt=%h busy=%0d hi=%h lo=%h", tag, op, rs, rt, n, bus.hi, bus.lo);
  endtask

  task automatic mt_op(input string tag, input md_op_e op, input logic [31:0] rs);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = rs;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    $display("txn %s op=%0d rs=%h hi=%h lo=%h", tag, op, rs, bus.hi, bus.lo);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.md_op    = MD_MULT;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.md_use_D = 1'b0;
    #12;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_md}, 32'd0);
    reset = 1'b0;
    tick();

    bus.md_use_D = 1'b1;
    #1;
    chk("idle_stall", {31'd0, bus.stall_md}, 32'd0);
    bus.md_use_D = 1'b0;

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0);
    run_op("div_negdiv", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);

    mt_op("mthi", MD_MTHI, 32'h1234_5678);
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_lo", bus.lo, 32'h8000_0000);
    mt_op("mtlo", MD_MTLO, 32'h0000_ABCD);
    chk("mtlo_lo", bus.lo, 32'h0000_ABCD);
    chk("mtlo_hi", bus.hi, 32'h1234_5678);
    mt_op("rsv6", MD_RSV6, 32'h0000_FFFF);
    chk("rsv6_hi", bus.hi, 32'h1234_5678);
    chk("rsv6_lo", bus.lo, 32'h0000_ABCD);

    bus.md_use_D = 1'b1;
    run_op("mult_stall", MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42, 0);
    bus.md_use_D = 1'b0;

    run_op("divu_illegal", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 2);
    $display("note: illegal starts flagged by bench: %0d", illegal_starts);

    mt_op("mthi5", MD_MTHI, 32'd5);
    mt_op("mtlo9", MD_MTLO, 32'd9);
`ifdef MD_DIV0_HOLD_EN
    run_op("div_by0", MD_DIV, 32'h55, 32'd0, 10, 32'd5, 32'd9, 0);
    run_op("divu_by0", MD_DIVU, 32'h77, 32'd0, 10, 32'd5, 32'd9, 0);
`else
    run_op("div_by0", MD_DIV, 32'h55, 32'd0, 10, 32'h55, 32'hFFFF_FFFF, 0);
    run_op("divu_by0", MD_DIVU, 32'h77, 32'd0, 10, 32'h77, 32'hFFFF_FFFF, 0);
`endif

    // Asynchronous reset in the 4th busy cycle of a DIV, away from any edge.
    bus.start  = 1'b1;
    bus.md_op  = MD_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);
    $display("txn async_reset_mid_div hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);

    run_op("multu_recover", MD_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
